// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and its schedulers.
package fifo_arb_pkg;

    // Largest requester count any scheduler in this family supports.
    localparam int MAX_NREQ = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Beat counter width: wide enough to hold BURST itself.
    function automatic int cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

    // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
    function automatic int onehot_to_idx(input logic [MAX_NREQ-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after index last, wrapping.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    // Scan (last+1) .. (last+NREQ) mod NREQ; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int               idx;
            logic [NREQ-1:0]  shifted;
            idx     = (int'(last) + k) % NREQ;
            shifted = req >> idx;
            if (!found && shifted[0]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among NREQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [WIDTH-1:0]      fifo_wdata,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = cnt_width(BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NREQ - 1);

    arb_state_e       state, state_d;
    logic [NREQ-1:0]  grant_d;
    logic [IDX_W-1:0] last, last_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             owner_req;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    // Decode the registered one-hot grant into the owner index for the data mux.
    always_comb begin
        owner = IDX_W'(onehot_to_idx(MAX_NREQ'(grant)));
    end

    // Write path: accept only from the owner, only while it requests and the FIFO has room.
    always_comb begin
        ack        = grant & req & {NREQ{~fifo_full}};
        fifo_wen   = |ack;
        fifo_wdata = (grant != '0) ? data[owner*WIDTH +: WIDTH] : '0;
        owner_req  = |(grant & req);
        busy       = (state == GRANT);
    end

    // Next-state logic: arbitrate in IDLE, count beats and detect release in GRANT.
    always_comb begin
        state_d = state;
        grant_d = grant;
        last_d  = last;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    grant_d = NREQ'(1) << winner;
                    last_d  = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (fifo_wen) begin
                    if (cnt == LAST_BEAT) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end else if (!owner_req) begin
                    // Owner gave up (even if full rose in the same cycle).
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; async reset aborts any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            last  <= LAST_RESET;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= state_d;
            grant <= grant_d;
            last  <= last_d;
            cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: producer queues drive req/data, a monitor scoreboards every write.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int WAIT_LIMIT = (NREQ - 1) * (BURST + 2) + NREQ;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] data = '0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       grant;
    logic                  fifo_full = 1'b0;
    logic                  fifo_wen;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  busy;

    typedef logic [WIDTH-1:0] word_q_t [$];
    word_q_t src   [NREQ];
    word_q_t exp_w [NREQ];

    logic [NREQ-1:0] mask  = '0;
    logic [NREQ-1:0] ack_s = '0;
    int n_checks = 0;
    int n_errs   = 0;
    int wait_cnt [NREQ];
    int max_wait = 0;

    fifo_wr_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .BURST (BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .grant      (grant),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic update_drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = mask[i] && (src[i].size() > 0);
            data[i*WIDTH +: WIDTH] = (src[i].size() > 0) ? src[i][0] : '0;
        end
    endtask

    task automatic load(input int i, input logic [WIDTH-1:0] w);
        src[i].push_back(w);
        exp_w[i].push_back(w);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            src[i].delete();
            exp_w[i].delete();
        end
        mask = '0;
        update_drive();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_full = 1'b0;
        clear_all();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || req != '0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(busy || req != '0), 32'd0);
    endtask

    // Producer model: advance past acked words just after the edge that consumed them.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack_s[i] && src[i].size() > 0) void'(src[i].pop_front());
        end
        update_drive();
    end

    // Monitor: scoreboard every write, check invariants, track waiting time.
    always @(negedge clk) begin
        if (!rst_n) begin
            ack_s = '0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end else begin
            ack_s = ack;
            check("no_write_while_full", 32'(fifo_wen & fifo_full), 32'd0);
            check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (fifo_wen) begin
                check("wen_has_ack", 32'(ack != '0), 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i]) begin
                        if (exp_w[i].size() == 0) check("unexpected_write", 32'(i), 32'hFFFF);
                        else check("wdata_order", 32'(fifo_wdata), 32'(exp_w[i].pop_front()));
                    end
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !grant[i]) begin
                    if (!fifo_full) wait_cnt[i]++;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    // Hard stop in case a wait is ever missed.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [NREQ-1:0] rr_order [5];

    initial begin
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;
        rr_order[4] = 4'b0001;

        // Reset state, sampled before any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wen", 32'(fifo_wen), 32'd0);
        check("rst_wdata", 32'(fifo_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single requester, 6 words: two bursts (4 + 2) with one bubble between.
        for (int j = 0; j < 6; j++) load(0, WIDTH'(8'h10 + j));
        mask = 4'b0001;
        update_drive();
        check("t1_c0_idle_grant", 32'(grant), 32'd0);
        check("t1_c0_no_ack", 32'(ack), 32'd0);
        step();
        check("t1_c1_grant", 32'(grant), 32'b0001);
        check("t1_c1_ack", 32'(ack), 32'b0001);
        for (int c = 2; c <= 4; c++) begin
            step();
            check("t1_burst_ack", 32'(ack), 32'b0001);
        end
        step();
        check("t1_c5_bubble_grant", 32'(grant), 32'd0);
        check("t1_c5_bubble_busy", 32'(busy), 32'd0);
        step();
        check("t1_c6_regrant", 32'(grant), 32'b0001);
        check("t1_c6_ack", 32'(ack), 32'b0001);
        step();
        check("t1_c7_ack", 32'(ack), 32'b0001);
        step();
        check("t1_c8_no_ack", 32'(ack), 32'd0);
        check("t1_c8_grant_held", 32'(grant), 32'b0001);
        step();
        check("t1_c9_released", 32'(grant), 32'd0);

        // All requesters held: 0,1,2,3,0 with 4 beats and one bubble each.
        do_reset();
        for (int j = 0; j < 8; j++) load(0, WIDTH'(8'h00 + j));
        for (int i = 1; i < NREQ; i++)
            for (int j = 0; j < 4; j++) load(i, WIDTH'(i * 16 + j));
        mask = 4'b1111;
        update_drive();
        for (int b = 0; b < 5; b++) begin
            step();
            check("t2_grant_order", 32'(grant), 32'(rr_order[b]));
            repeat (4) step();
            check("t2_bubble", 32'(grant), 32'd0);
        end
        wait_idle(20);

        // Full stall on owner 2 after two beats.
        do_reset();
        for (int j = 0; j < 4; j++) load(2, WIDTH'(8'hA0 + j));
        mask = 4'b0100;
        update_drive();
        step();
        check("t3_grant", 32'(grant), 32'b0100);
        step();
        check("t3_second_ack", 32'(ack), 32'b0100);
        step();
        fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("t3_stall_ack", 32'(ack), 32'd0);
            check("t3_stall_wen", 32'(fifo_wen), 32'd0);
            check("t3_stall_grant", 32'(grant), 32'b0100);
            if (c < 4) step();
        end
        step();
        fifo_full = 1'b0;
        #1;
        check("t3_resume_ack1", 32'(ack), 32'b0100);
        step();
        check("t3_resume_ack2", 32'(ack), 32'b0100);
        step();
        check("t3_release", 32'(grant), 32'd0);

        // Early release by owner 1; search then resumes from index 2.
        do_reset();
        load(1, 8'hB0);
        for (int j = 0; j < 4; j++) load(0, WIDTH'(8'hC0 + j));
        for (int j = 0; j < 4; j++) load(3, WIDTH'(8'hD0 + j));
        mask = 4'b0010;
        update_drive();
        step();
        check("t4_grant1", 32'(grant), 32'b0010);
        check("t4_ack1", 32'(ack), 32'b0010);
        mask = 4'b1011;
        update_drive();
        step();
        check("t4_drop_grant_held", 32'(grant), 32'b0010);
        check("t4_drop_no_ack", 32'(ack), 32'd0);
        step();
        check("t4_released", 32'(grant), 32'd0);
        step();
        check("t4_next_grant", 32'(grant), 32'b1000);
        wait_idle(40);

        // Asynchronous reset during the second beat of owner 0.
        do_reset();
        for (int j = 0; j < 4; j++) load(0, WIDTH'(8'hE0 + j));
        mask = 4'b0001;
        update_drive();
        step();
        check("t5_grant", 32'(grant), 32'b0001);
        step();
        check("t5_second_beat_ack", 32'(ack), 32'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_grant", 32'(grant), 32'd0);
        check("t5_async_ack", 32'(ack), 32'd0);
        check("t5_async_wen", 32'(fifo_wen), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_one_word_written", 32'(exp_w[0].size()), 32'd3);
        clear_all();
        step();
        step();
        rst_n = 1'b1;
        load(0, 8'hF0);
        load(3, 8'h70);
        mask = 4'b1001;
        update_drive();
        step();
        check("t5_grant_after_rst", 32'(grant), 32'b0001);
        wait_idle(20);

        // Random soak: producers refill at random, full toggles at random.
        do_reset();
        mask = '1;
        update_drive();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (src[i].size() < 3 && $urandom_range(0, 2) == 0) load(i, WIDTH'($urandom));
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            update_drive();
            step();
        end
        fifo_full = 1'b0;
        wait_idle(400);
        check("fairness_bound", 32'(max_wait > WAIT_LIMIT), 32'd0);

        for (int i = 0; i < NREQ; i++) check("all_words_written", 32'(exp_w[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
